led_mode_sequencer: RTL

//  Scheduler for the 8-LED bank: owns o_led and sequences it through selectable display

---
 rtl/led_mode_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/led_mode_sequencer.sv
// 8-LED mode sequencer: a prescaled step tick drives COUNT/CHASE/BOUNCE patterns, and debounced buttons pick the mode or freeze stepping.
// Defining LED_MODE_BREATHE_EN adds the PWM BREATHE mode as mode 3.

module led_mode_sequencer #(
    parameter int TICK_DIV = 250000,
    parameter int DB_TICKS = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_next,
    input  logic       i_btn_hold,
    output logic [7:0] o_led,
    output logic [1:0] o_mode,
    output logic       o_tick
);

    localparam int CW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam int RW = (DB_TICKS < 2) ? 1 : $clog2(DB_TICKS);

    typedef enum logic [1:0] {
        M_COUNT   = 2'd0,
        M_CHASE   = 2'd1,
        M_BOUNCE  = 2'd2,
        M_BREATHE = 2'd3
    } mode_t;

    logic [CW-1:0] cnt;
    logic          tick_now;

    assign tick_now = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt    <= '0;
            o_tick <= 1'b0;
        end else begin
            o_tick <= tick_now;
            cnt    <= tick_now ? '0 : cnt + 1'b1;
        end
    end

    // Button conditioning: index 0 = next, index 1 = hold.
    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] accept;
    logic [1:0] synced;

    assign raw = {i_btn_hold, i_btn_next};

    for (genvar b = 0; b < 2; b++) begin : g_db
        logic [1:0]    sync;
        logic [RW-1:0] run;
        logic          level;

        assign synced[b] = sync[1];
        assign lvl[b]    = level;
        assign accept[b] = tick_now && (sync[1] != level) && (run == RW'(DB_TICKS - 1));

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                sync  <= '0;
                run   <= '0;
                level <= 1'b0;
            end else begin
                sync <= {sync[0], raw[b]};
                if (tick_now) begin
                    if (sync[1] == level) begin
                        run <= '0;
                    end else if (accept[b]) begin
                        level <= sync[1];
                        run   <= '0;
                    end else begin
                        run <= run + 1'b1;
                    end
                end
            end
        end
    end

    logic next_evt;
    logic hold;
    logic step;

    // next_evt lands on the tick edge that accepts the press, so it can collide with a step.
    assign next_evt = accept[0] && synced[0];
    assign hold     = lvl[1];
    assign step     = tick_now && !hold;

    mode_t      mode;
    logic [7:0] count;
    logic [7:0] onehot;
    logic       dir_left;
    logic [7:0] disp;

`ifdef LED_MODE_BREATHE_EN
    logic [7:0] duty;
    logic       duty_up;
    logic [7:0] pwm_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + 8'd1;
    end
`endif

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            M_COUNT:  next_mode = M_CHASE;
            M_CHASE:  next_mode = M_BOUNCE;
`ifdef LED_MODE_BREATHE_EN
            M_BOUNCE: next_mode = M_BREATHE;
`endif
            default:  next_mode = M_COUNT;
        endcase
    endfunction

    always_comb begin
        disp = count;
        case (mode)
            M_CHASE, M_BOUNCE: disp = onehot;
`ifdef LED_MODE_BREATHE_EN
            M_BREATHE:         disp = {8{pwm_cnt < duty}};
`endif
            default:           disp = count;
        endcase
    end

    assign o_mode = mode;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode     <= M_COUNT;
            count    <= '0;
            onehot   <= 8'h01;
            dir_left <= 1'b1;
            o_led    <= '0;
`ifdef LED_MODE_BREATHE_EN
            duty     <= '0;
            duty_up  <= 1'b1;
`endif
        end else begin
            o_led <= disp;
            if (next_evt) begin
                // Mode change wins over a coincident step.
                mode     <= next_mode(mode);
                count    <= '0;
                onehot   <= 8'h01;
                dir_left <= 1'b1;
`ifdef LED_MODE_BREATHE_EN
                duty     <= '0;
                duty_up  <= 1'b1;
`endif
            end else if (step) begin
                case (mode)
                    M_COUNT: count <= count + 8'd1;
                    M_CHASE: onehot <= {onehot[6:0], onehot[7]};
                    M_BOUNCE: begin
                        if (dir_left) begin
                            if (onehot[7]) begin
                                dir_left <= 1'b0;
                                onehot   <= 8'h40;
                            end else begin
                                onehot <= onehot << 1;
                            end
                        end else begin
                            if (onehot[0]) begin
                                dir_left <= 1'b1;
                                onehot   <= 8'h02;
                            end else begin
                                onehot <= onehot >> 1;
                            end
                        end
                    end
`ifdef LED_MODE_BREATHE_EN
                    M_BREATHE: begin
                        if (duty_up) begin
                            if (duty == 8'hFF) begin
                                duty_up <= 1'b0;
                                duty    <= 8'hFE;
                            end else begin
                                duty <= duty + 8'd1;
                            end
                        end else begin
                            if (duty == 8'h00) begin
                                duty_up <= 1'b1;
                                duty    <= 8'h01;
                            end else begin
                                duty <= duty - 8'd1;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
